tick_timer_sched: RTL and testbench

Shared-timebase delay scheduler for the 50 MHz domain. Up to N_REQ requesters (display blink, sprite step, debounce, mode-change hold-off) ask for a delay in prescaled ticks. The block arbitrates them round-robin onto one prescaler and one countdown engine, then returns a one-cycle completion pulse to the requester it granted. It sits beside the 1 s event generator and replaces per-client free-running counters in the VGA control path.

---
 rtl/tick_sched_pkg.sv | 15 +
 rtl/tick_rr_pick.sv | 30 +++
 rtl/tick_timer_sched.sv | 117 +++++++++++
 tb/tb_tick_timer_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick delay scheduler and related timebase blocks:
// FSM state encoding and default prescaler / delay-width constants.
package tick_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tsched_state_e;

   localparam int PRESCALE_1MS = 50000;
   localparam int PRESCALE_1S  = 50000000;
   localparam int DLY_W_DEF    = 16;

endpackage

// File: rtl/tick_rr_pick.sv
// Combinational round-robin picker: selects the first set request bit
// starting one position after the most recently granted index.
module tick_rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_last,
   output logic                     o_valid,
   output logic [$clog2(N_REQ)-1:0] o_idx
);

   localparam int CH_W = $clog2(N_REQ);

   int w_c;

   // Scan from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_c     = 0;
      for (int i = N_REQ; i >= 1; i--) begin
         w_c = (int'(i_last) + i) % N_REQ;
         if (i_req[w_c[CH_W-1:0]]) begin
            o_valid = 1'b1;
            o_idx   = w_c[CH_W-1:0];
         end
      end
   end

endmodule

// File: rtl/tick_timer_sched.sv
// Shared-timebase delay scheduler: round-robin grants one requester at a time
// onto a single prescaler + countdown, then pulses that requester's done bit.
module tick_timer_sched
   import tick_sched_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DLY_W    = DLY_W_DEF,
   parameter int PRESCALE = PRESCALE_1MS
) (
   input  logic                     clk50m,
   input  logic                     rstn,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ*DLY_W-1:0]   i_dly,
   input  logic                     i_abort,
   output logic [N_REQ-1:0]         o_gnt,
   output logic [N_REQ-1:0]         o_done,
   output logic                     o_busy,
   output logic [$clog2(N_REQ)-1:0] o_ch
);

   localparam int CH_W  = $clog2(N_REQ);
   localparam int PRE_W = $clog2(PRESCALE);

   tsched_state_e      r_state;
   logic [PRE_W-1:0]   r_pre;
   logic [DLY_W-1:0]   r_rem;
   logic [CH_W-1:0]    r_last;
   logic [CH_W-1:0]    r_ch;
   logic [N_REQ-1:0]   r_gnt;
   logic [N_REQ-1:0]   r_done;
   logic               r_busy;

   logic               w_valid;
   logic [CH_W-1:0]    w_idx;
   logic [N_REQ-1:0]   w_gnt_oh;
   logic [N_REQ-1:0]   w_done_oh;
   logic [DLY_W-1:0]   w_dly_sel;
   logic               w_tick;

   tick_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .i_req   (i_req),
      .i_last  (r_last),
      .o_valid (w_valid),
      .o_idx   (w_idx)
   );

   assign w_gnt_oh  = N_REQ'(1) << w_idx;
   assign w_done_oh = N_REQ'(1) << r_ch;
   assign w_dly_sel = i_dly[w_idx*DLY_W +: DLY_W];
   assign w_tick    = (r_pre == PRE_W'(PRESCALE - 1));

   always_ff @(posedge clk50m or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_pre   <= '0;
         r_rem   <= '0;
         r_last  <= CH_W'(N_REQ - 1);
         r_ch    <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_gnt  <= '0;
         r_done <= '0;
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_state <= RUN;
                  r_gnt   <= w_gnt_oh;
                  r_ch    <= w_idx;
                  r_last  <= w_idx;
                  r_rem   <= w_dly_sel;
                  r_pre   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               // Abort outranks completion; exit is decided before r_rem decrements.
               if (i_abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_pre   <= '0;
               end else if (r_rem == '0) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= w_done_oh;
               end else if (w_tick) begin
                  r_pre <= '0;
                  r_rem <= r_rem - 1'b1;
                  if (r_rem == DLY_W'(1)) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= w_done_oh;
                  end
               end else begin
                  r_pre <= r_pre + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_gnt  = r_gnt;
   assign o_done = r_done;
   assign o_busy = r_busy;
   assign o_ch   = r_ch;

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched with PRESCALE=10, N_REQ=4, DLY_W=16:
// table of single-channel transactions plus hand sequences for RR, abort, reset.
module tb_tick_timer_sched;

   logic        clk50m = 1'b0;
   logic        rstn;
   logic [3:0]  req;
   logic [63:0] dly_bus;
   logic        abort;
   logic [3:0]  o_gnt;
   logic [3:0]  o_done;
   logic        o_busy;
   logic [1:0]  o_ch;

   int checks = 0;
   int errors = 0;

   tick_timer_sched #(
      .N_REQ    (4),
      .DLY_W    (16),
      .PRESCALE (10)
   ) dut (
      .clk50m  (clk50m),
      .rstn    (rstn),
      .i_req   (req),
      .i_dly   (dly_bus),
      .i_abort (abort),
      .o_gnt   (o_gnt),
      .o_done  (o_done),
      .o_busy  (o_busy),
      .o_ch    (o_ch)
   );

   always #10 clk50m = ~clk50m;

   typedef struct {
      logic [3:0]  req;
      int          ch;
      logic [15:0] dly;
      int          exp_done;
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge clk50m);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One isolated transaction; optionally rewrites the channel's delay the cycle after grant.
   task automatic run_txn(input string nm, input logic [3:0] mask, input int ch,
                          input logic [15:0] dly, input int exp_done, input bit chg);
      int         n;
      int         busy_n;
      logic [3:0] done_v;
      req = mask;
      dly_bus[ch*16 +: 16] = dly;
      step();
      chk({nm, ".gnt"}, 32'(o_gnt), 32'(mask));
      chk({nm, ".ch"}, 32'(o_ch), 32'(ch));
      chk({nm, ".busy_at_gnt"}, 32'(o_busy), 32'd1);
      req    = 4'b0000;
      n      = 0;
      busy_n = 1;
      done_v = 4'b0000;
      while (n < 2000) begin
         step();
         n++;
         if (chg && n == 1) dly_bus[ch*16 +: 16] = 16'd9;
         if (o_done != 4'b0000) begin
            done_v = o_done;
            break;
         end
         if (o_busy) busy_n++;
      end
      chk({nm, ".done_latency"}, 32'(n), 32'(exp_done));
      chk({nm, ".done_onehot"}, 32'(done_v), 32'(mask));
      chk({nm, ".busy_cycles"}, 32'(busy_n), 32'(exp_done));
      chk({nm, ".busy_at_done"}, 32'(o_busy), 32'd0);
      step();
      chk({nm, ".done_cleared"}, 32'(o_done), 32'd0);
   endtask

   initial begin
      int          gcyc[5];
      int          dcyc[5];
      logic [3:0]  gval[5];
      int          ng;
      int          nd;
      int          cyc;
      int          bad;
      logic [3:0]  exp_rr[5];

      vecs[0] = '{req: 4'b0001, ch: 0, dly: 16'd3, exp_done: 30};
      vecs[1] = '{req: 4'b0100, ch: 2, dly: 16'd0, exp_done: 1};
      vecs[2] = '{req: 4'b0010, ch: 1, dly: 16'd2, exp_done: 20};
      vecs[3] = '{req: 4'b0100, ch: 2, dly: 16'd7, exp_done: 70};
      vecs[4] = '{req: 4'b1000, ch: 3, dly: 16'd1, exp_done: 10};
      exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      rstn    = 1'b0;
      req     = 4'b0000;
      dly_bus = '0;
      abort   = 1'b0;
      #1;
      chk("reset.gnt", 32'(o_gnt), 32'd0);
      chk("reset.done", 32'(o_done), 32'd0);
      chk("reset.busy", 32'(o_busy), 32'd0);
      chk("reset.ch", 32'(o_ch), 32'd0);
      step();
      step();
      rstn = 1'b1;
      step();

      for (int v = 0; v < 5; v++)
         run_txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].ch, vecs[v].dly, vecs[v].exp_done, 1'b0);

      // Round robin: all four requesting, dly=1 each.
      dly_bus = {16'd1, 16'd1, 16'd1, 16'd1};
      req     = 4'b1111;
      ng = 0; nd = 0; cyc = 0;
      while (nd < 5 && cyc < 400) begin
         step();
         cyc++;
         if (o_gnt != 4'b0000 && ng < 5) begin
            gval[ng] = o_gnt;
            gcyc[ng] = cyc;
            ng++;
            if (ng == 5) req = 4'b0000;
         end
         if (o_done != 4'b0000 && nd < 5) begin
            dcyc[nd] = cyc;
            nd++;
         end
      end
      chk("rr.grant_count", 32'(ng), 32'd5);
      chk("rr.done_count", 32'(nd), 32'd5);
      if (ng == 5 && nd == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr.gnt%0d", i), 32'(gval[i]), 32'(exp_rr[i]));
            chk($sformatf("rr.gnt_to_done%0d", i), 32'(dcyc[i] - gcyc[i]), 32'd10);
            if (i < 4) chk($sformatf("rr.done_to_gnt%0d", i), 32'(gcyc[i+1] - dcyc[i]), 32'd2);
         end
      end
      step();

      // Abort ch1 at cycle 23 after grant, ch3 pending.
      dly_bus = {16'd1, 16'd0, 16'd5, 16'd0};
      req     = 4'b1010;
      step();
      chk("abort.gnt", 32'(o_gnt), 32'b0010);
      chk("abort.ch", 32'(o_ch), 32'd1);
      req = 4'b1000;
      bad = 0;
      for (int c = 1; c <= 23; c++) begin
         step();
         if (o_done != 4'b0000 || !o_busy) bad++;
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort.run_glitches", 32'(bad), 32'd0);
      chk("abort.busy_low", 32'(o_busy), 32'd0);
      chk("abort.no_done", 32'(o_done), 32'd0);
      step();
      chk("abort.next_gnt", 32'(o_gnt), 32'b1000);
      chk("abort.next_ch", 32'(o_ch), 32'd3);
      req = 4'b0000;
      bad = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c < 10 && o_done != 4'b0000) bad++;
         if (c == 10) chk("abort.ch3_done", 32'(o_done), 32'b1000);
      end
      chk("abort.ch3_early_done", 32'(bad), 32'd0);
      step();

      // Reset asserted at cycle 17 of a ch0 dly=4 run.
      dly_bus[15:0] = 16'd4;
      req = 4'b0001;
      step();
      chk("rst.gnt", 32'(o_gnt), 32'b0001);
      req = 4'b0000;
      repeat (17) step();
      chk("rst.busy_before", 32'(o_busy), 32'd1);
      rstn = 1'b0;
      #1;
      chk("rst.gnt0", 32'(o_gnt), 32'd0);
      chk("rst.done0", 32'(o_done), 32'd0);
      chk("rst.busy0", 32'(o_busy), 32'd0);
      chk("rst.ch0", 32'(o_ch), 32'd0);
      step();
      step();
      rstn = 1'b1;
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (o_done != 4'b0000 || o_gnt != 4'b0000 || o_busy) bad++;
      end
      chk("rst.quiet_after_release", 32'(bad), 32'd0);
      run_txn("rst_new", 4'b0001, 0, 16'd4, 40, 1'b0);

      // i_dly changes after grant must not affect the running delay.
      run_txn("dly_chg", 4'b0001, 0, 16'd2, 20, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
